instruction_fetch_controller: RTL and testbench

Sequences the InstructionMemory read port for the RISC-V core.
- Owns the program counter and drives the memory address.
- Captures returned instructions into a 2-entry fetch buffer and presents {pc, instr} to decode over a valid/ready handshake.
- Handles start/halt control and branch/jump redirects with buffer flush.

---
 rtl/riscv_fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 55 +++++
 rtl/instruction_fetch_controller.sv | 115 +++++++++++
 tb/tb_instruction_fetch_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package riscv_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry FIFO of {pc, instr}; head is always entry 0, pop shifts the rest down.
module fetch_buffer
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int unsigned W = $bits(fetch_entry_t);

  logic [DEPTH*W-1:0] mem_q, mem_d;
  logic [CW-1:0]      count_d, wr_idx;
  logic               pop_ok, push_ok;

  // Packed storage lets a pop be a plain shift, so any DEPTH works without pointer wrap.
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count < CW'(DEPTH)) || pop_ok);
    wr_idx  = pop_ok ? (count - CW'(1)) : count;
    mem_d   = pop_ok ? (mem_q >> W) : mem_q;
    if (push_ok) begin
      mem_d[W*int'(wr_idx) +: W] = din;
    end
    count_d = count;
    if (push_ok && !pop_ok) begin
      count_d = count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      mem_q <= mem_d;
      count <= count_d;
    end
  end

  assign head = mem_q[W-1:0];

endmodule

// File: rtl/instruction_fetch_controller.sv
// Program counter, fetch FSM and decode handshake for the InstructionMemory read port.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misalign_err output for unaligned redirects.
module instruction_fetch_controller
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic [31:0] fetch_cnt
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, cnt_q;
  logic [CW-1:0]   count;
  fetch_entry_t    head, hold_q, din;
  logic            pop;

  always_comb begin
    pop     = (count != '0) && out_ready;
    imem_en = (state_q == RUN) && !redirect_valid && !halt_req &&
              ((count < CW'(DEPTH)) || pop);
    din     = '{pc: pc_q, instr: imem_instr};

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~ALIGN_MASK;
    end else if (imem_en) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end

    // A redirect freezes the FSM; only an unaligned target (when checked) moves it.
    state_d = state_q;
    if (!redirect_valid) begin
      case (state_q)
        IDLE:    if (start)    state_d = RUN;
        RUN:     if (halt_req) state_d = HALT;
        HALT:    if (start)    state_d = RUN;
        default:               state_d = IDLE;
      endcase
    end
`ifdef FETCH_ALIGN_CHECK_EN
    if (redirect_valid && ((redirect_pc & ALIGN_MASK) != '0)) begin
      state_d = HALT;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      hold_q  <= '{pc: '0, instr: NOP_INSTR};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (imem_en) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (out_valid) begin
        hold_q <= head;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid && ((redirect_pc & ALIGN_MASK) != '0)) begin
      misalign_err <= 1'b1;
    end
  end
`endif

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (imem_en),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? head.pc    : hold_q.pc;
  assign out_instr = out_valid ? head.instr : hold_q.instr;
  assign imem_addr = pc_q;
  assign busy      = (state_q == RUN);
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench: directed vector table, corner sequences, and randomized run vs a queue model.
module tb_instruction_fetch_controller;

  localparam logic [31:0] KEY   = 32'hA5A50000;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_instr, out_instr, out_pc, fetch_cnt;
  logic        imem_en, out_valid, busy;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign imem_instr = imem_addr ^ KEY;

  instruction_fetch_controller #(.RESET_PC(32'h00000000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .busy(busy), .fetch_cnt(fetch_cnt)
`ifdef FETCH_ALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched entries, architectural pc, and a run/idle/halt mode.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  int          m_mode;  // 0 idle, 1 running, 2 halted
  logic [31:0] m_pc, m_cnt, m_lpc, m_linstr;
  bit          m_err;

  function automatic void m_reset();
    mq.delete();
    m_mode = 0; m_pc = 0; m_cnt = 0; m_lpc = 0; m_linstr = NOP; m_err = 0;
  endfunction

  function automatic bit m_fetch();
    return m_mode == 1 && !redirect_valid && !halt_req &&
           (mq.size() < DEPTH || (mq.size() > 0 && out_ready));
  endfunction

  task automatic m_check();
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("out_pc", out_pc, mq.size() > 0 ? mq[0].pc : m_lpc);
    chk("out_instr", out_instr, mq.size() > 0 ? mq[0].instr : m_linstr);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_en", {31'd0, imem_en}, {31'd0, m_fetch()});
    chk("busy", {31'd0, busy}, {31'd0, m_mode == 1});
    chk("fetch_cnt", fetch_cnt, m_cnt);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
`endif
  endtask

  function automatic void m_edge();
    bit pop = mq.size() > 0 && out_ready;
    bit en  = m_fetch();
    if (mq.size() > 0) begin
      m_lpc = mq[0].pc;
      m_linstr = mq[0].instr;
    end
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc - (redirect_pc % 4);
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc % 4 != 0) begin
        m_err = 1;
        m_mode = 2;
      end
`endif
    end else begin
      if (pop) void'(mq.pop_front());
      if (en) begin
        mq.push_back('{m_pc, m_pc ^ KEY});
        m_pc += 4;
        m_cnt += 1;
      end
      if (m_mode == 1 && halt_req) m_mode = 2;
      else if (m_mode != 1 && start) m_mode = 1;
    end
  endfunction

  task automatic cyc(input bit s, input bit h, input bit rv, input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    start = s; halt_req = h; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1 m_check();
    @(posedge clk);
    m_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; halt_req = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    @(negedge clk);
    rst = 0;
    m_reset();
  endtask

  typedef struct {
    bit s, h, rv; logic [31:0] rpc; bit rdy;
    bit ev; logic [31:0] epc; bit enop; logic [31:0] eaddr; bit een, ebusy; logic [31:0] ecnt;
  } vec_t;
  vec_t tv[16];

  initial begin
    rst = 1; start = 0; halt_req = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    m_reset();

    //          s h rv rpc     rdy  ev epc     nop addr    en busy cnt
    tv[0]  = '{1,0,0, 32'h0,   1,   0, 32'h0,   1, 32'h0,   0, 0, 0};
    tv[1]  = '{0,0,0, 32'h0,   1,   0, 32'h0,   1, 32'h0,   1, 1, 0};
    tv[2]  = '{0,0,0, 32'h0,   1,   1, 32'h0,   0, 32'h4,   1, 1, 1};
    tv[3]  = '{0,0,0, 32'h0,   1,   1, 32'h4,   0, 32'h8,   1, 1, 2};
    tv[4]  = '{0,0,0, 32'h0,   1,   1, 32'h8,   0, 32'hC,   1, 1, 3};
    tv[5]  = '{0,0,1, 32'h100, 0,   1, 32'hC,   0, 32'h10,  0, 1, 4};
    tv[6]  = '{0,0,0, 32'h0,   0,   0, 32'hC,   0, 32'h100, 1, 1, 4};
    tv[7]  = '{0,0,0, 32'h0,   0,   1, 32'h100, 0, 32'h104, 1, 1, 5};
    tv[8]  = '{0,0,0, 32'h0,   0,   1, 32'h100, 0, 32'h108, 0, 1, 6};
    tv[9]  = '{0,0,0, 32'h0,   1,   1, 32'h100, 0, 32'h108, 1, 1, 6};
    tv[10] = '{0,0,0, 32'h0,   1,   1, 32'h104, 0, 32'h10C, 1, 1, 7};
    tv[11] = '{0,1,0, 32'h0,   1,   1, 32'h108, 0, 32'h110, 0, 1, 8};
    tv[12] = '{0,0,0, 32'h0,   1,   1, 32'h10C, 0, 32'h110, 0, 0, 8};
    tv[13] = '{0,0,0, 32'h0,   1,   0, 32'h10C, 0, 32'h110, 0, 0, 8};
    tv[14] = '{1,0,0, 32'h0,   1,   0, 32'h10C, 0, 32'h110, 0, 0, 8};
    tv[15] = '{0,0,0, 32'h0,   1,   0, 32'h10C, 0, 32'h110, 1, 1, 8};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = tv[i].s; halt_req = tv[i].h; redirect_valid = tv[i].rv;
      redirect_pc = tv[i].rpc; out_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, tv[i].ev});
      chk($sformatf("v%0d_pc", i), out_pc, tv[i].epc);
      chk($sformatf("v%0d_instr", i), out_instr, tv[i].enop ? NOP : (tv[i].epc ^ KEY));
      chk($sformatf("v%0d_addr", i), imem_addr, tv[i].eaddr);
      chk($sformatf("v%0d_en", i), {31'd0, imem_en}, {31'd0, tv[i].een});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tv[i].ebusy});
      chk($sformatf("v%0d_cnt", i), fetch_cnt, tv[i].ecnt);
      @(posedge clk);
    end

    // PC wrap through the top of the address space
    do_reset();
    cyc(1, 0, 0, 32'h0, 1);
    cyc(0, 0, 1, 32'hFFFFFFFC, 1);
    cyc(0, 0, 0, 32'h0, 1);
    #1;
    chk("wrap_pc0", out_pc, 32'hFFFFFFFC);
    chk("wrap_addr", imem_addr, 32'h00000000);
    cyc(0, 0, 0, 32'h0, 1);
    #1;
    chk("wrap_pc1", out_pc, 32'h00000000);

    // Asynchronous reset with a full buffer
    do_reset();
    cyc(1, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 0;
    m_reset();

`ifdef FETCH_ALIGN_CHECK_EN
    do_reset();
    cyc(1, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 1, 32'h102, 1);
    #1;
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_busy", {31'd0, busy}, 32'd0);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_valid", {31'd0, out_valid}, 32'd0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom % 6 == 0) ? (32'hFFFFFFF0 + ($urandom % 16)) : ($urandom & 32'h00000FFF);
      cyc($urandom % 6 == 0, $urandom % 14 == 0, $urandom % 18 == 0, rpc, $urandom % 3 != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
